golden_nonce_collector: RTL and testbench

Multi-core successor to the single-core golden-nonce path: gathers golden-nonce reports from `NUM_CORES` parallel `fpgaminer_core` instances, corrects each for pipeline offset, and queues them for the host interface. Sits between the core array and the serial/JTAG reporter. Replaces the single-register `golden_nonce` output with per-core capture, round-robin arbitration, a FIFO, loss accounting, and a work-change flush.

---
 rtl/golden_nonce_collector_pkg.sv | 26 ++
 rtl/golden_nonce_collector_if.sv | 26 ++
 rtl/golden_nonce_collector_fifo.sv | 61 ++++++
 rtl/golden_nonce_collector.sv | 141 ++++++++++++++
 tb/tb_golden_nonce_collector.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/golden_nonce_collector_pkg.sv
// Shared miner types and helpers.
// Nonce/drop widths, report entry layout, clog2.
package miner_pkg;

  localparam int NONCE_W  = 32;
  localparam int DROP_W   = 16;
  localparam int ID_MAX_W = 8;

  typedef struct packed {
    logic [ID_MAX_W-1:0] core;
    logic [NONCE_W-1:0]  nonce;
  } entry_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int id_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/golden_nonce_collector_if.sv
// Golden-nonce report stream (valid/ready).
// master: collector drives valid/core/nonce; slave: reporter drives ready.
interface golden_out_if #(
  parameter int ID_W = 2
);

  logic                         out_valid;
  logic                         out_ready;
  logic [ID_W-1:0]              out_core;
  logic [miner_pkg::NONCE_W-1:0] out_nonce;

  modport master (
    output out_valid,
    output out_core,
    output out_nonce,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_core,
    input  out_nonce,
    output out_ready
  );

endinterface

// File: rtl/golden_nonce_collector_fifo.sv
// Synchronous FIFO with count, full/empty and flush.
// Ports: push/din, pop/dout (0 when empty), full, empty, count.
module golden_fifo #(
  parameter int WIDTH      = 34,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   cnt_q;
  logic                  wr_en;
  logic                  rd_en;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (DEPTH_LOG2+1)'(DEPTH));
  assign count = cnt_q;

  // A pop frees a slot, so a full FIFO may still accept a push.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_en)
        cnt_q <= cnt_q + 1'b1;
      else if (!wr_en && rd_en)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/golden_nonce_collector.sv
// Per-core golden-nonce capture, round-robin arbiter, FIFO, drop count.
// Ports: clk, reset(n), flush, gn_valid/gn_nonce, out stream, counts.
module golden_nonce_collector
  import miner_pkg::*;
#(
  parameter int          NUM_CORES    = 4,
  parameter int          DEPTH_LOG2   = 3,
  parameter logic [31:0] NONCE_ADJUST = 32'd0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [NUM_CORES-1:0]         gn_valid,
  input  logic [NONCE_W*NUM_CORES-1:0] gn_nonce,
  golden_out_if.master                 out,
  output logic [DEPTH_LOG2:0]          fifo_count,
  output logic [DROP_W-1:0]            drop_count
);

  localparam int ID_W = id_width(NUM_CORES);
  localparam int EW   = ID_W + NONCE_W;

  logic [NUM_CORES-1:0] hold_v;
  logic [NUM_CORES-1:0] hold_v_d;
  logic [NUM_CORES-1:0] drop_vec;
  logic [NONCE_W-1:0]   hold_n   [NUM_CORES];
  logic [NONCE_W-1:0]   hold_n_d [NUM_CORES];

  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   rr_nxt;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W-1:0]   cand;
  logic              gnt_any;
  logic              grant;
  logic              taken;
  logic              pop;
  logic              full;
  logic              empty;
  logic [EW-1:0]     push_data;
  logic [EW-1:0]     head;
  logic [DROP_W-1:0] drop_q;
  logic [DROP_W-1:0] drop_d;
  logic [31:0]       drop_sum;
  int                j;

  assign pop = out.out_ready && !empty;

  // First valid hold at or after rr_ptr, wrapping.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    j       = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_CORES) j = j - NUM_CORES;
      cand = ID_W'(j);
      if (!gnt_any && hold_v[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign grant = gnt_any && (!full || pop) && !flush;

  assign rr_nxt = (gnt_idx == ID_W'(NUM_CORES-1)) ?
                  '0 : gnt_idx + 1'b1;

  assign push_data = {gnt_idx, hold_n[gnt_idx]};

  // A grant empties the hold that same edge, so a
  // coincident strobe reloads it instead of dropping.
  always_comb begin
    drop_vec = '0;
    taken    = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      hold_v_d[i] = hold_v[i];
      hold_n_d[i] = hold_n[i];
      taken = grant && (gnt_idx == ID_W'(i));
      if (taken) hold_v_d[i] = 1'b0;
      if (gn_valid[i]) begin
        if (hold_v[i] && !taken) begin
          drop_vec[i] = 1'b1;
        end else begin
          hold_v_d[i] = 1'b1;
          hold_n_d[i] = gn_nonce[NONCE_W*i +: NONCE_W]
                        - NONCE_ADJUST;
        end
      end
    end
  end

  always_comb begin
    drop_sum = 32'(drop_q);
    for (int i = 0; i < NUM_CORES; i++)
      drop_sum = drop_sum + 32'(drop_vec[i]);
    drop_d = (|drop_sum[31:DROP_W]) ? '1 : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_v <= '0;
      rr_ptr <= '0;
      drop_q <= '0;
      for (int i = 0; i < NUM_CORES; i++)
        hold_n[i] <= '0;
    end else if (flush) begin
      hold_v <= '0;
      rr_ptr <= '0;
    end else begin
      hold_v <= hold_v_d;
      drop_q <= drop_d;
      for (int i = 0; i < NUM_CORES; i++)
        hold_n[i] <= hold_n_d[i];
      if (grant) rr_ptr <= rr_nxt;
    end
  end

  golden_fifo #(
    .WIDTH      (EW),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .flush (flush),
    .push  (grant),
    .din   (push_data),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign out.out_valid = !empty;
  assign out.out_core  = head[EW-1 -: ID_W];
  assign out.out_nonce = head[NONCE_W-1:0];
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_golden_nonce_collector.sv
// Scoreboard bench for golden_nonce_collector.
// 4 cores, depth 8, adjust 256.
module tb_golden_nonce_collector;

  localparam logic [31:0] ADJ = 32'd256;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic [3:0]   gn_valid = '0;
  logic [127:0] gn_nonce = '0;
  logic [3:0]   fifo_count;
  logic [15:0]  drop_count;

  golden_out_if #(.ID_W(2)) oif ();

  golden_nonce_collector #(
    .NUM_CORES    (4),
    .DEPTH_LOG2   (3),
    .NONCE_ADJUST (ADJ)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .gn_valid   (gn_valid),
    .gn_nonce   (gn_nonce),
    .out        (oif),
    .fifo_count (fifo_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  core;
    logic [31:0] nonce;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   exp_drops = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nonce(input int c, input logic [31:0] v);
    gn_nonce[32*c +: 32] = v;
  endtask

  task automatic expect_out(input int c, input logic [31:0] raw);
    exp_t e;
    e.core  = 2'(c);
    e.nonce = raw - ADJ;
    q.push_back(e);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  function automatic logic [31:0] bn(input int b, input int c);
    return 32'h1000_0000 * (b + 1) + 32'h100 * c + 32'h55;
  endfunction

  task automatic test_reset();
    #2;
    n_checks++;
    if (oif.out_valid !== 1'b0)
      $display("FAIL reset_valid got=%0b exp=0", oif.out_valid);
    else n_pass++;
    n_checks++;
    if (fifo_count !== 4'd0)
      $display("FAIL reset_count got=%0d exp=0", fifo_count);
    else n_pass++;
    n_checks++;
    if (drop_count !== 16'd0)
      $display("FAIL reset_drop got=%0d exp=0", drop_count);
    else n_pass++;
    n_checks++;
    if (oif.out_core !== 2'd0 || oif.out_nonce !== 32'd0)
      $display("FAIL reset_head got=%0d/%h exp=0/0",
               oif.out_core, oif.out_nonce);
    else n_pass++;
    #10 reset = 1'b1;
  endtask

  task automatic test_single(input string tag);
    exp_t e;
    oif.out_ready = 1'b1;
    set_nonce(0, 32'h0e33347a);
    e.core = 2'd0;
    e.nonce = 32'h0e33337a;
    q.push_back(e);
    gn_valid = 4'b0001;
    tick();
    gn_valid = '0;
    n_checks++;
    if (oif.out_valid !== 1'b0)
      $display("FAIL %s_lat1 got=%0b exp=0", tag, oif.out_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (oif.out_valid !== 1'b1)
      $display("FAIL %s_lat2 got=%0b exp=1", tag, oif.out_valid);
    else n_pass++;
    e = q.pop_front();
    n_checks++;
    if (oif.out_core !== e.core || oif.out_nonce !== e.nonce)
      $display("FAIL %s_head got=%0d/%h exp=%0d/%h", tag,
               oif.out_core, oif.out_nonce, e.core, e.nonce);
    else n_pass++;
    tick();
    n_checks++;
    if (oif.out_valid !== 1'b0)
      $display("FAIL %s_popped got=%0b exp=0", tag, oif.out_valid);
    else n_pass++;
  endtask

  task automatic test_wrap_rr();
    exp_t e;
    int   got;
    int   first;
    int   last;
    logic [3:0] order [3];
    do_flush();
    oif.out_ready = 1'b1;
    for (int c = 0; c < 4; c++)
      set_nonce(c, (c == 2) ? 32'h10 : 32'hA000_0000 + 32'h1111 * c);
    for (int r = 0; r < 3; r++) begin
      if (r == 1) begin
        expect_out(1, gn_nonce[63:32]);
        gn_valid = 4'b0010;
      end else begin
        for (int k = 0; k < 4; k++) begin
          int c;
          c = (r == 0) ? k : (k + 2) % 4;
          expect_out(c, gn_nonce[32*c +: 32]);
        end
        gn_valid = 4'b1111;
      end
      tick();
      gn_valid = '0;
      got = 0;
      first = -1;
      last = -1;
      for (int cyc = 0; cyc < 20 && q.size() > 0; cyc++) begin
        if (oif.out_valid === 1'b1) begin
          e = q.pop_front();
          if (first < 0) first = cyc;
          last = cyc;
          got++;
          n_checks++;
          if (oif.out_core !== e.core || oif.out_nonce !== e.nonce)
            $display("FAIL rr%0d_order got=%0d/%h exp=%0d/%h", r,
                     oif.out_core, oif.out_nonce, e.core, e.nonce);
          else n_pass++;
        end
        tick();
      end
      n_checks++;
      if (q.size() != 0 || last - first != got - 1)
        $display("FAIL rr%0d_rate got=%0d in %0d cyc exp=%0d back-to-back",
                 r, got, last - first + 1, (r == 1) ? 1 : 4);
      else n_pass++;
      q.delete();
    end
  endtask

  task automatic test_full_drop();
    exp_t e;
    int   got;
    do_flush();
    oif.out_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      for (int c = 0; c < 4; c++) begin
        set_nonce(c, bn(b, c));
        expect_out(c, bn(b, c));
      end
      gn_valid = 4'b1111;
      tick();
      gn_valid = '0;
      repeat (5) tick();
    end
    n_checks++;
    if (fifo_count !== 4'd8)
      $display("FAIL full_count got=%0d exp=8", fifo_count);
    else n_pass++;
    set_nonce(2, 32'hDEAD_BEEF);
    gn_valid = 4'b0100;
    tick();
    gn_valid = '0;
    exp_drops++;
    n_checks++;
    if (drop_count !== 16'(exp_drops))
      $display("FAIL full_drop got=%0d exp=%0d", drop_count, exp_drops);
    else n_pass++;
    oif.out_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 12; cyc++) begin
      if (got == 1) begin
        n_checks++;
        if (fifo_count !== 4'd8)
          $display("FAIL full_pushpop got=%0d exp=8", fifo_count);
        else n_pass++;
      end
      if (oif.out_valid === 1'b1) begin
        e = q.pop_front();
        got++;
        n_checks++;
        if (oif.out_core !== e.core || oif.out_nonce !== e.nonce)
          $display("FAIL full_drain%0d got=%0d/%h exp=%0d/%h", got,
                   oif.out_core, oif.out_nonce, e.core, e.nonce);
        else n_pass++;
      end
      tick();
    end
    n_checks++;
    if (got != 12 || oif.out_valid !== 1'b0)
      $display("FAIL full_total got=%0d exp=12", got);
    else n_pass++;
    q.delete();
  endtask

  task automatic test_same_cycle();
    exp_t e;
    int   got;
    do_flush();
    oif.out_ready = 1'b1;
    set_nonce(1, 32'h1234_5678);
    expect_out(1, 32'h1234_5678);
    gn_valid = 4'b0010;
    tick();
    set_nonce(1, 32'h8765_4321);
    expect_out(1, 32'h8765_4321);
    tick();
    gn_valid = '0;
    got = 0;
    for (int cyc = 0; cyc < 10 && got < 2; cyc++) begin
      if (oif.out_valid === 1'b1) begin
        e = q.pop_front();
        got++;
        n_checks++;
        if (oif.out_core !== e.core || oif.out_nonce !== e.nonce)
          $display("FAIL same_out%0d got=%0d/%h exp=%0d/%h", got,
                   oif.out_core, oif.out_nonce, e.core, e.nonce);
        else n_pass++;
      end
      tick();
    end
    n_checks++;
    if (got != 2 || drop_count !== 16'(exp_drops))
      $display("FAIL same_drop got=%0d outs %0d drops exp=2 outs %0d drops",
               got, drop_count, exp_drops);
    else n_pass++;
    q.delete();
  endtask

  task automatic test_flush();
    int seen;
    do_flush();
    oif.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) set_nonce(c, bn(0, c));
    gn_valid = 4'b1111;
    tick();
    gn_valid = '0;
    repeat (5) tick();
    gn_valid = 4'b0001;
    tick();
    gn_valid = '0;
    repeat (2) tick();
    n_checks++;
    if (fifo_count !== 4'd5)
      $display("FAIL flush_pre got=%0d exp=5", fifo_count);
    else n_pass++;
    gn_valid = 4'b1110;
    tick();
    flush = 1'b1;
    gn_valid = 4'b0010;
    oif.out_ready = 1'b1;
    tick();
    flush = 1'b0;
    gn_valid = '0;
    n_checks++;
    if (oif.out_valid !== 1'b0 || fifo_count !== 4'd0)
      $display("FAIL flush_clear got=%0b/%0d exp=0/0",
               oif.out_valid, fifo_count);
    else n_pass++;
    n_checks++;
    if (drop_count !== 16'(exp_drops))
      $display("FAIL flush_drop got=%0d exp=%0d", drop_count, exp_drops);
    else n_pass++;
    seen = 0;
    repeat (8) begin
      if (oif.out_valid === 1'b1) seen++;
      tick();
    end
    n_checks++;
    if (seen != 0)
      $display("FAIL flush_stale got=%0d exp=0", seen);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    oif.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) set_nonce(c, bn(1, c));
    gn_valid = 4'b1111;
    tick();
    gn_valid = '0;
    repeat (3) tick();
    n_checks++;
    if (oif.out_valid !== 1'b1 || drop_count === 16'd0)
      $display("FAIL areset_pre got=%0b/%0d exp=1/nonzero",
               oif.out_valid, drop_count);
    else n_pass++;
    #3 reset = 1'b0;
    #1;
    n_checks++;
    if (oif.out_valid !== 1'b0 || fifo_count !== 4'd0)
      $display("FAIL areset_out got=%0b/%0d exp=0/0",
               oif.out_valid, fifo_count);
    else n_pass++;
    n_checks++;
    if (drop_count !== 16'd0)
      $display("FAIL areset_drop got=%0d exp=0", drop_count);
    else n_pass++;
    n_checks++;
    if (oif.out_core !== 2'd0 || oif.out_nonce !== 32'd0)
      $display("FAIL areset_head got=%0d/%h exp=0/0",
               oif.out_core, oif.out_nonce);
    else n_pass++;
    #2 reset = 1'b1;
    q.delete();
    exp_drops = 0;
    test_single("post");
  endtask

  task automatic test_saturate();
    int total;
    oif.out_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      for (int c = 0; c < 4; c++) set_nonce(c, bn(b, c));
      gn_valid = 4'b1111;
      tick();
      gn_valid = '0;
      repeat (5) tick();
    end
    gn_valid = 4'b1111;
    tick();
    total = exp_drops + 4;
    n_checks++;
    if (drop_count !== 16'(total))
      $display("FAIL sat_multi got=%0d exp=%0d", drop_count, total);
    else n_pass++;
    repeat (16400) begin
      tick();
      total += 4;
    end
    gn_valid = '0;
    if (total > 32'hFFFF) total = 32'hFFFF;
    n_checks++;
    if (drop_count !== 16'(total))
      $display("FAIL sat_clamp got=%0d exp=%0d", drop_count, total);
    else n_pass++;
  endtask

  initial begin
    oif.out_ready = 1'b0;
    test_reset();
    test_single("single");
    test_wrap_rr();
    test_full_drop();
    test_same_cycle();
    test_flush();
    test_async_reset();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
